param_mux_fifo: RTL

- N-channel input buffer. Each channel has its own FIFO, with a type-parametrised payload and a parametrised depth.
- A round-robin arbiter merges the channels onto one valid/ready output stream.
- Next-generation channel buffer for the parameter-propagation flow. Numeric and type parameters pass through a top level into a per-channel sub-module instantiated in a generate loop.
- Sits between multiple producers and a single consumer.

---
 rtl/param_mux_fifo_pkg.sv | 13 +
 rtl/param_chan_fifo.sv | 76 +++++++
 rtl/param_mux_fifo.sv | 115 +++++++++++
 3 files changed

// File: rtl/param_mux_fifo_pkg.sv
// Shared defaults and helpers for the per-channel buffer and its merge arbiter.
// Holds no logic; latency and backpressure are defined by the modules that import it.
package param_mux_fifo_pkg;

    typedef logic [1:0][31:0] default_data_t;

    localparam int DefaultDepth = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/param_chan_fifo.sv
// Circular FIFO for one channel. The head is visible the cycle after its push edge.
// The caller gates push with !full_o and pop with !empty_o; flush_i overrides both.
module param_chan_fifo
    import param_mux_fifo_pkg::*;
#(
    parameter int  Depth    = DefaultDepth,
    parameter type data_t   = default_data_t,
    localparam int CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  data_t               wdata_i,
    output data_t               rdata_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] usage_o
);

    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    data_t                mem_q [Depth];
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + CntWidth'(1);
                2'b01:   cnt_d = cnt_q - CntWidth'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CntWidth'(Depth));

endmodule

// File: rtl/param_mux_fifo.sv
// N per-channel FIFOs merged round-robin onto one stream; a push reaches valid_o one cycle later.
// Per-channel ready_o drops only when that FIFO is full; an unaccepted output is held until taken.
module param_mux_fifo
    import param_mux_fifo_pkg::*;
#(
    parameter int  NumChan  = 4,
    parameter int  Depth    = DefaultDepth,
    parameter type data_t   = default_data_t,
    localparam int IdxWidth = idx_width(NumChan),
    localparam int CntWidth = $clog2(Depth + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic [NumChan-1:0]               valid_i,
    output logic [NumChan-1:0]               ready_o,
    input  data_t                            data_i [NumChan],
    output logic                             valid_o,
    input  logic                             ready_i,
    output data_t                            data_o,
    output logic [IdxWidth-1:0]              chan_o,
    output logic [NumChan-1:0][CntWidth-1:0] usage_o
);

    if (NumChan < 1 || Depth < 1) begin : g_param_err
        $error("param_mux_fifo: NumChan and Depth must both be at least 1");
    end

    logic [NumChan-1:0]  push, pop, full, empty;
    data_t               rdata [NumChan];

    logic [IdxWidth-1:0] rr_q, rr_d;
    logic                lock_q, lock_d;
    logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
    logic [IdxWidth-1:0] search_idx, sel;
    logic                found, hs;
    int                  probe;

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        assign push[c] = valid_i[c] & ~full[c];
        assign pop[c]  = hs & (sel == IdxWidth'(c));

        param_chan_fifo #(
            .Depth  (Depth),
            .data_t (data_t)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .push_i  (push[c]),
            .pop_i   (pop[c]),
            .wdata_i (data_i[c]),
            .rdata_o (rdata[c]),
            .full_o  (full[c]),
            .empty_o (empty[c]),
            .usage_o (usage_o[c])
        );
    end

    // First non-empty channel at or above rr_q, wrapping modulo NumChan.
    always_comb begin
        search_idx = '0;
        found      = 1'b0;
        probe      = 0;
        for (int i = 0; i < NumChan; i++) begin
            probe = int'(rr_q) + i;
            if (probe >= NumChan) probe = probe - NumChan;
            if (!found && !empty[probe[IdxWidth-1:0]]) begin
                found      = 1'b1;
                search_idx = probe[IdxWidth-1:0];
            end
        end
    end

    assign sel     = lock_q ? lock_idx_q : search_idx;
    assign valid_o = |(~empty);
    assign hs      = valid_o & ready_i;
    assign ready_o = ~full;
    assign data_o  = valid_o ? rdata[sel] : '0;
    assign chan_o  = valid_o ? sel : '0;

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (flush_i) begin
            rr_d       = '0;
            lock_d     = 1'b0;
            lock_idx_d = '0;
        end else if (hs) begin
            rr_d   = (int'(sel) == NumChan - 1) ? '0 : sel + IdxWidth'(1);
            lock_d = 1'b0;
        end else if (valid_o) begin
            // Pin the presented channel so later arrivals cannot change an offered beat.
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o) && $stable(chan_o)));

endmodule
